dot_product_stream: RTL

//  Streaming signed dot product: accepts N element pairs per beat over a valid/ready

---
 rtl/dot_product_stream_pkg.sv | 50 +++++
 rtl/dot_product_stream_if.sv | 41 ++++
 rtl/dot_product_stream_dp_adder_tree.sv | 45 ++++
 rtl/dot_product_stream.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/dot_product_stream_pkg.sv
// Shared widths, signed range helpers and the pipeline control bundle
// for the streaming dot product. Imported by every dot_product_stream file.
package dot_product_stream_pkg;

    // Wide signed scratch type for range checks and clamping; any
    // accumulator up to 64 bits passes through it without loss.
    localparam int CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    // valid/last pair carried alongside each pipeline stage
    typedef struct packed {
        logic valid;
        logic last;
    } stage_ctl_t;

    function automatic int prod_width(input int dw);
        return 2 * dw;
    endfunction

    function automatic int tree_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    // Guard bits cover 2^len_log2 beats, so the accumulator never wraps.
    function automatic int acc_width(input int dw, input int n,
                                     input int len_log2);
        return tree_width(dw, n) + len_log2;
    endfunction

    function automatic calc_t max_signed(input int w);
        return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    endfunction

    function automatic calc_t min_signed(input int w);
        return -(calc_t'(1) <<< (w - 1));
    endfunction

    function automatic logic fits_signed(input calc_t v, input int w);
        return (v <= max_signed(w)) && (v >= min_signed(w));
    endfunction

    function automatic calc_t sat_signed(input calc_t v, input int w);
        calc_t r;
        r = v;
        if (v > max_signed(w)) r = max_signed(w);
        if (v < min_signed(w)) r = min_signed(w);
        return r;
    endfunction

endpackage

// File: rtl/dot_product_stream_if.sv
// Beat input and scalar result buses of the streaming dot product.
// Input: in_valid/in_ready/in_last + N lane pairs; output: out_valid/out_ready + sums/ovf/beats.
interface dot_product_stream_in_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic [N-1:0][DW-1:0] inp1;
    logic [N-1:0][DW-1:0] inp2;

    modport master (
        output in_valid, in_last, inp1, inp2,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_last, inp1, inp2,
        output in_ready
    );
endinterface

interface dot_product_stream_out_if #(
    parameter int OW       = 16,
    parameter int LEN_LOG2 = 8
);
    logic                out_valid;
    logic                out_ready;
    logic [OW-1:0]       sums;
    logic                out_ovf;
    logic [LEN_LOG2:0]   out_beats;

    modport master (
        output out_valid, sums, out_ovf, out_beats,
        input  out_ready
    );
    modport slave (
        input  out_valid, sums, out_ovf, out_beats,
        output out_ready
    );
endinterface

// File: rtl/dot_product_stream_dp_adder_tree.sv
// Registered N-input signed adder (stage 2 of the dot product pipeline).
// Ports: clk, reset, en (advance), ctl_i/data_i in, ctl_o/sum_o registered out.
module dp_adder_tree
    import dot_product_stream_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 16,
    parameter int SW = IW + $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  stage_ctl_t            ctl_i,
    input  logic [N-1:0][IW-1:0]  data_i,
    output stage_ctl_t            ctl_o,
    output logic signed [SW-1:0]  sum_o
);

    logic signed [SW-1:0] sum_d;
    logic signed [SW-1:0] sum_q;
    stage_ctl_t           ctl_q;

    // Each lane is sign-extended to the full sum width before adding;
    // for N=1 this is just a register stage.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N; i++) begin
            sum_d = sum_d + SW'(signed'(data_i[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_q <= '0;
            sum_q <= '0;
        end else if (en) begin
            ctl_q <= ctl_i;
            sum_q <= sum_d;
        end
    end

    assign ctl_o = ctl_q;
    assign sum_o = sum_q;

endmodule

// File: rtl/dot_product_stream.sv
// Streaming signed dot product: N lane pairs per beat, accumulated until last.
// Ports: clk, reset (sync, active-high), in_s (beat bus, slave), out_m (result bus, master).
module dot_product_stream
    import dot_product_stream_pkg::*;
#(
    parameter int N        = 4,
    parameter int DW       = 8,
    parameter int LEN_LOG2 = 8,
    parameter int OW       = 16,
    parameter int SATURATE = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    dot_product_stream_in_if.slave   in_s,
    dot_product_stream_out_if.master out_m
);

    localparam int PW = prod_width(DW);
    localparam int TW = tree_width(DW, N);
    localparam int AW = acc_width(DW, N, LEN_LOG2);
    localparam int CW = LEN_LOG2 + 1;
    localparam logic [CW-1:0] MAX_BEATS = {1'b1, {LEN_LOG2{1'b0}}};

    // Global stall: the whole pipe advances only when the result
    // register is free or being drained this cycle.
    logic en;

    // Stage 1: lane products
    logic [N-1:0][PW-1:0] p_d;
    logic [N-1:0][PW-1:0] p_q;
    stage_ctl_t           s1_d;
    stage_ctl_t           s1_q;

    // Stage 2: adder tree output
    stage_ctl_t           s2;
    logic signed [TW-1:0] t_sum;

    // Stage 3: accumulator and beat counter
    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] acc_n;
    logic                 first_q;
    logic                 first_d;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [CW-1:0]        cnt_n;
    logic                 close;
    calc_t                acc_wide;

    // Result register
    logic                 out_valid_q;
    logic                 out_valid_d;
    logic [OW-1:0]        sums_q;
    logic [OW-1:0]        sums_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic [CW-1:0]        beats_q;
    logic [CW-1:0]        beats_d;

    assign en          = !out_valid_q || out_m.out_ready;
    assign in_s.in_ready = en;

    always_comb begin
        p_d = '0;
        for (int i = 0; i < N; i++) begin
            p_d[i] = PW'(signed'(in_s.inp1[i])) * PW'(signed'(in_s.inp2[i]));
        end
        s1_d.valid = in_s.in_valid;
        s1_d.last  = in_s.in_last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= '0;
            p_q  <= '0;
        end else if (en) begin
            s1_q <= s1_d;
            if (in_s.in_valid) begin
                p_q <= p_d;
            end
        end
    end

    dp_adder_tree #(
        .N  (N),
        .IW (PW),
        .SW (TW)
    ) u_tree (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .ctl_i  (s1_q),
        .data_i (p_q),
        .ctl_o  (s2),
        .sum_o  (t_sum)
    );

    always_comb begin
        // first_q restarts both the sum and the beat count
        acc_n    = (first_q ? {AW{1'b0}} : acc_q) + AW'(t_sum);
        cnt_n    = first_q ? CW'(1) : cnt_q + CW'(1);
        // a full-length vector closes even without in_last
        close    = s2.last || (cnt_n == MAX_BEATS);
        acc_wide = calc_t'(acc_n);

        acc_d       = acc_q;
        first_d     = first_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q && !out_m.out_ready;
        sums_d      = sums_q;
        ovf_d       = ovf_q;
        beats_d     = beats_q;

        if (en && s2.valid) begin
            if (close) begin
                sums_d      = (SATURATE != 0) ? OW'(sat_signed(acc_wide, OW))
                                              : OW'(acc_wide);
                ovf_d       = !fits_signed(acc_wide, OW);
                beats_d     = cnt_n;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                first_d     = 1'b1;
            end else begin
                acc_d       = acc_n;
                cnt_d       = cnt_n;
                first_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            first_q     <= 1'b1;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            sums_q      <= '0;
            ovf_q       <= 1'b0;
            beats_q     <= '0;
        end else begin
            acc_q       <= acc_d;
            first_q     <= first_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            sums_q      <= sums_d;
            ovf_q       <= ovf_d;
            beats_q     <= beats_d;
        end
    end

    assign out_m.out_valid = out_valid_q;
    assign out_m.sums      = sums_q;
    assign out_m.out_ovf   = ovf_q;
    assign out_m.out_beats = beats_q;

endmodule
